inv_addkey_mixcol: RTL and testbench

Decryption round stage that consumes the 128-bit output of the inverse S-box layer, XORs in the round key (AddRoundKey) and applies InvMixColumns one 32-bit column per cycle. A valid/ready handshake sits on both sides so the round controller can stall it. A per-block `last_round` flag bypasses InvMixColumns for the final decryption round, and latency is identical in both modes.

---
 rtl/aes_dec_pkg.sv | 35 +++
 rtl/inv_mix_column.sv | 18 +
 rtl/inv_addkey_mixcol.sv | 107 ++++++++++
 tb/tb_inv_addkey_mixcol.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared types and GF(2^8) helpers for the AES decryption datapath
package aes_dec_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] a);
    gf_mul09 = xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
    gf_mul0b = xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
    gf_mul0d = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
    gf_mul0e = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// rtl/inv_mix_column.sv - combinational InvMixColumns on one 32-bit column
module inv_mix_column
  import aes_dec_pkg::*;
(
  input  aes_col_t i_col,
  output aes_col_t o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign o_col[31:24] = gf_mul0e(w_a0) ^ gf_mul0b(w_a1) ^ gf_mul0d(w_a2) ^ gf_mul09(w_a3);
  assign o_col[23:16] = gf_mul09(w_a0) ^ gf_mul0e(w_a1) ^ gf_mul0b(w_a2) ^ gf_mul0d(w_a3);
  assign o_col[15:8]  = gf_mul0d(w_a0) ^ gf_mul09(w_a1) ^ gf_mul0e(w_a2) ^ gf_mul0b(w_a3);
  assign o_col[7:0]   = gf_mul0b(w_a0) ^ gf_mul0d(w_a1) ^ gf_mul09(w_a2) ^ gf_mul0e(w_a3);

endmodule

// File: rtl/inv_addkey_mixcol.sv
// rtl/inv_addkey_mixcol.sv - AddRoundKey then column-serial InvMixColumns with valid/ready on both sides
module inv_addkey_mixcol
  import aes_dec_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  aes_state_t   i_in_data,
  input  aes_state_t   i_in_key,
  input  logic         i_in_last,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output aes_state_t   o_out_data
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  fsm_state_t       r_state;
  aes_state_t       r_buf;
  logic [COL_W-1:0] r_col;
  logic             r_last;
  logic             r_out_valid;

  aes_col_t   w_col_in;
  aes_col_t   w_col_mix;
  aes_col_t   w_col_out;
  aes_state_t w_buf_next;
  logic       w_accept;

  inv_mix_column u_imc (
    .i_col (w_col_in),
    .o_col (w_col_mix)
  );

  // Column 0 occupies the MSBs; the single mixer is shared across columns via r_col.
  always_comb begin
    w_col_in = '0;
    for (int c = 0; c < COLS; c++) begin
      if (r_col == COL_W'(c)) w_col_in = r_buf[127-32*c -: 32];
    end
  end

  assign w_col_out = r_last ? w_col_in : w_col_mix;

  always_comb begin
    w_buf_next = r_buf;
    for (int c = 0; c < COLS; c++) begin
      if (r_col == COL_W'(c)) w_buf_next[127-32*c -: 32] = w_col_out;
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_buf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_col       <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_buf   <= i_in_data ^ i_in_key;
            r_last  <= i_in_last;
            r_col   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_buf <= w_buf_next;
          r_col <= r_col + 1'b1;
          if (r_col == COL_W'(COLS - 1)) begin
            r_col       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_buf   <= i_in_data ^ i_in_key;
              r_last  <= i_in_last;
              r_col   <= '0;
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// tb/tb_inv_addkey_mixcol.sv - self-checking bench with directed vectors and a randomized scoreboard
module tb_inv_addkey_mixcol;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [127:0] i_in_data;
  logic [127:0] i_in_key;
  logic         i_in_last;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [127:0] o_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  inv_addkey_mixcol #(.COLS(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_key    (i_in_key),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic l);
    logic [127:0] s, o;
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] r;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    s = d ^ k;
    if (l) return s;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(a[j], coef[(j - i + 4) % 4]);
        o[127-32*c-8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic xfer(input logic [127:0] d, input logic [127:0] k, input logic l,
                      output logic [127:0] res, output int lat);
    int guard;
    @(negedge i_clk);
    i_in_data = d; i_in_key = k; i_in_last = l; i_in_valid = 1'b1;
    #1;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      @(negedge i_clk); #1;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 128'(o_in_ready), 128'(1));
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_in_data  = {$urandom, $urandom, $urandom, $urandom};
    i_in_key   = {$urandom, $urandom, $urandom, $urandom};
    i_in_last  = ~l;
    chk("busy_in_ready", 128'(o_in_ready), 128'(0));
    wait_valid(lat);
    res = o_out_data;
  endtask

  task automatic drain();
    @(negedge i_clk); i_out_ready = 1'b1;
    @(posedge i_clk); #1; i_out_ready = 1'b0;
  endtask

  logic [127:0] res, d, k, held, exp_q[$];
  int lat, sent, got, cyc;
  logic l, acc;

  initial begin
    i_rst_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_key = '0;
    i_in_last = 1'b0; i_out_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_in_ready", 128'(o_in_ready), 128'(1));
    chk("rst_out_valid", 128'(o_out_valid), 128'(0));
    chk("rst_out_data", o_out_data, 128'(0));
    @(negedge i_clk); i_rst_n = 1'b1;

    xfer(128'h8e4da1bc_01010101_01010101_01010101, '0, 1'b0, res, lat);
    chk("known_data", res, 128'hdb135345_01010101_01010101_01010101);
    chk("known_lat", 128'(lat), 128'(4));
    drain();

    xfer({4{32'hc6c6c6c6}}, '0, 1'b0, res, lat);
    chk("ident_data", res, {4{32'hc6c6c6c6}});
    drain();

    xfer(128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1, res, lat);
    chk("last_data", res, 128'hffeeddcc_bbaa9988_77665544_33221100);
    chk("last_lat", 128'(lat), 128'(4));
    drain();
    chk("idle_after_drain", 128'(o_out_valid), 128'(0));

    // Back-pressure then back-to-back accept
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    xfer(d, k, 1'b0, res, lat);
    chk("bp_first", res, model(d, k, 1'b0));
    held = o_out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      chk("bp_stable", o_out_data, held);
      chk("bp_in_ready", 128'(o_in_ready), 128'(0));
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge i_clk);
    i_out_ready = 1'b1; i_in_valid = 1'b1; i_in_data = d; i_in_key = k; i_in_last = 1'b0;
    #1;
    chk("b2b_in_ready", 128'(o_in_ready), 128'(1));
    @(posedge i_clk); #1;
    i_in_valid = 1'b0; i_out_ready = 1'b0; i_in_data = '0;
    chk("b2b_valid_drop", 128'(o_out_valid), 128'(0));
    wait_valid(lat);
    chk("b2b_lat", 128'(lat), 128'(4));
    chk("b2b_data", o_out_data, model(d, k, 1'b0));
    drain();

    // Reset while column 2 is next to be processed
    @(negedge i_clk);
    i_in_valid = 1'b1; i_in_data = {4{32'h12345678}}; i_in_key = {4{32'h9abcdef0}}; i_in_last = 1'b0;
    @(posedge i_clk); #1; i_in_valid = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(o_out_valid), 128'(0));
    chk("mrst_in_ready", 128'(o_in_ready), 128'(1));
    chk("mrst_out_data", o_out_data, 128'(0));
    @(negedge i_clk); i_rst_n = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    xfer(d, k, 1'b0, res, lat);
    chk("mrst_after", res, model(d, k, 1'b0));
    chk("mrst_lat", 128'(lat), 128'(4));
    drain();

    // Random regression with stalls on both sides
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      @(negedge i_clk);
      cyc++;
      if (!i_in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        i_in_data  = {$urandom, $urandom, $urandom, $urandom};
        i_in_key   = {$urandom, $urandom, $urandom, $urandom};
        i_in_last  = 1'($urandom_range(1));
        i_in_valid = 1'b1;
      end
      i_out_ready = ($urandom_range(3) != 0);
      #1;
      acc = i_in_valid && o_in_ready;
      if (acc) begin
        exp_q.push_back(model(i_in_data, i_in_key, i_in_last));
        sent++;
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 128'(1), 128'(0));
        else chk("rnd_data", o_out_data, exp_q.pop_front());
        got++;
      end
      @(posedge i_clk); #1;
      if (acc) i_in_valid = 1'b0;
    end
    chk("rnd_count", 128'(got), 128'(1000));
    chk("rnd_leftover", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
